// File: rtl/dot_vec_loader.sv
// Assembles lanes-wide operand beats into k-element vector pairs for the dot-product unit.
// Latency: vector valid the cycle after its last beat is accepted; replaces a departing vector with no gap.
// Backpressure: buffers slot + one full fill; o_ready drops only while a completed fill is held.
module dot_vec_loader #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [lanes-1:0][bit_width-1:0]   i_elem_a,
  input  logic [lanes-1:0][bit_width-1:0]   i_elem_b,
  input  logic                              i_clear,
  output logic                              o_vec_valid,
  input  logic                              i_vec_ready,
  output logic [k-1:0][bit_width-1:0]       o_vec_a,
  output logic [k-1:0][bit_width-1:0]       o_vec_b
);

  localparam int beats = k / lanes;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

  typedef logic [k-1:0][bit_width-1:0] vec_t;

  logic [cnt_w-1:0] fill_cnt;
  logic             fill_full;
  vec_t             fill_a;
  vec_t             fill_b;
  vec_t             fill_a_nxt;
  vec_t             fill_b_nxt;

  logic accept;
  logic handoff;
  logic last_beat;
  logic slot_free;
  logic load_new;
  logic drain_held;

  // A clear in the same cycle suppresses the beat, including a last beat.
  assign accept     = i_valid && o_ready && !i_clear;
  assign handoff    = o_vec_valid && i_vec_ready;
  assign last_beat  = accept && (fill_cnt == last_cnt);
  assign slot_free  = !o_vec_valid || handoff;
  assign load_new   = last_beat && slot_free;
  assign drain_held = fill_full && handoff;

  assign o_ready = i_rst_n && !fill_full;

  // Fill buffer with the current beat merged in, so a last beat can go straight to the slot.
  always_comb begin
    fill_a_nxt = fill_a;
    fill_b_nxt = fill_b;
    if (accept) begin
      for (int j = 0; j < beats; j++) begin
        if (fill_cnt == cnt_w'(j)) begin
          for (int l = 0; l < lanes; l++) begin
            fill_a_nxt[j*lanes + l] = i_elem_a[l];
            fill_b_nxt[j*lanes + l] = i_elem_b[l];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      fill_a    <= '0;
      fill_b    <= '0;
    end else begin
      if (i_clear) begin
        fill_cnt <= '0;
      end else if (accept) begin
        fill_cnt <= last_beat ? '0 : fill_cnt + cnt_w'(1);
      end

      if (accept) begin
        fill_a <= fill_a_nxt;
        fill_b <= fill_b_nxt;
      end

      if (last_beat && !slot_free) begin
        fill_full <= 1'b1;
      end else if (drain_held) begin
        fill_full <= 1'b0;
      end
    end
  end

  // Output slot: held fill has priority; it can never coincide with a new last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vec_valid <= 1'b0;
      o_vec_a     <= '0;
      o_vec_b     <= '0;
    end else begin
      if (drain_held) begin
        o_vec_a     <= fill_a;
        o_vec_b     <= fill_b;
        o_vec_valid <= 1'b1;
      end else if (load_new) begin
        o_vec_a     <= fill_a_nxt;
        o_vec_b     <= fill_b_nxt;
        o_vec_valid <= 1'b1;
      end else if (handoff) begin
        o_vec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_vec_loader.sv
// Scoreboarded bench for dot_vec_loader: an element-level model queues expected vectors,
// a forked monitor pops and compares them at every handoff.
module tb_dot_vec_loader;

  localparam int bw = 8;
  localparam int kk = 32;
  localparam int ln = 4;
  localparam int nb = kk / ln;

  typedef logic [kk-1:0][bw-1:0] vec_t;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_clear = 1'b0;
  logic                   i_vec_ready = 1'b0;
  logic [ln-1:0][bw-1:0]  i_elem_a = '0;
  logic [ln-1:0][bw-1:0]  i_elem_b = '0;
  logic                   o_ready;
  logic                   o_vec_valid;
  vec_t                   o_vec_a;
  vec_t                   o_vec_b;

  dot_vec_loader #(.bit_width(bw), .k(kk), .lanes(ln)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_elem_a    (i_elem_a),
    .i_elem_b    (i_elem_b),
    .i_clear     (i_clear),
    .o_vec_valid (o_vec_valid),
    .i_vec_ready (i_vec_ready),
    .o_vec_a     (o_vec_a),
    .o_vec_b     (o_vec_b)
  );

  always #5 i_clk = ~i_clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ho_cyc[$];
  vec_t exp_a_q[$];
  vec_t exp_b_q[$];

  // Reference model: element values by vector position, completed vectors go to the queues.
  int   part_n = 0;
  int   part_a[kk];
  int   part_b[kk];
  int   kind = 0;
  bit   vr = 1'b0;
  bit   last_acc = 1'b0;
  int   nvec = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_expected();
    vec_t ea;
    vec_t eb;
    for (int i = 0; i < kk; i++) begin
      ea[i] = part_a[i][bw-1:0];
      eb[i] = part_b[i][bw-1:0];
    end
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    part_n = 0;
  endtask

  // Drives one cycle of inputs just after the rising edge and updates the model.
  task automatic send(input bit vld, input bit clr);
    @(posedge i_clk);
    #1;
    i_valid     = vld;
    i_clear     = clr;
    i_vec_ready = vr;
    for (int l = 0; l < ln; l++) begin
      int idx;
      int va;
      int vb;
      idx = part_n * ln + l;
      case (kind)
        0: begin va = idx; vb = -idx; end
        1: begin va = 127; vb = -128; end
        default: begin
          va = int'($urandom_range(255)) - 128;
          vb = int'($urandom_range(255)) - 128;
        end
      endcase
      i_elem_a[l] = va[bw-1:0];
      i_elem_b[l] = vb[bw-1:0];
      if (vld && o_ready && !clr) begin
        part_a[idx] = va;
        part_b[idx] = vb;
      end
    end
    last_acc = vld && o_ready && !clr;
    if (clr) begin
      part_n = 0;
    end else if (last_acc) begin
      part_n++;
      if (part_n == nb) push_expected();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic send_vec(input int kd, input bit gap);
    kind = kd;
    for (int j = 0; j < nb; j++) begin
      int tries;
      tries = 0;
      do begin
        send(1'b1, 1'b0);
        tries++;
      end while (!last_acc && tries < 100);
      if (!last_acc) begin
        checks++;
        failures++;
        $display("FAIL beat_accept_timeout actual=stalled required=accepted");
      end
      if (gap) send(1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    vr = 1'b1;
    n = 0;
    while ((exp_a_q.size() != 0 || o_vec_valid) && n < 100) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("drained_queue", exp_a_q.size(), 0);
  endtask

  task automatic monitor();
    vec_t held_a;
    vec_t held_b;
    bit   hold_pend;
    hold_pend = 1'b0;
    held_a = '0;
    held_b = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          checks++;
          if (!o_vec_valid || o_vec_a !== held_a || o_vec_b !== held_b) begin
            failures++;
            $display("FAIL slot_stable actual valid=%0b required valid=1 with unchanged data", o_vec_valid);
          end
        end
        if (o_vec_valid && i_vec_ready) begin
          ho_cyc.push_back(cyc);
          nvec++;
          checks++;
          if (exp_a_q.size() == 0) begin
            failures++;
            $display("FAIL handoff_unexpected vec=%0d actual=valid required=no vector pending", nvec);
          end else begin
            vec_t ea;
            vec_t eb;
            int   bad;
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            if (o_vec_a !== ea || o_vec_b !== eb) begin
              bad = 0;
              for (int i = kk - 1; i >= 0; i--)
                if (o_vec_a[i] !== ea[i] || o_vec_b[i] !== eb[i]) bad = i;
              failures++;
              $display("FAIL handoff_data vec=%0d elem=%0d actual a=%0d b=%0d required a=%0d b=%0d",
                       nvec, bad, $signed(o_vec_a[bad]), $signed(o_vec_b[bad]),
                       $signed(ea[bad]), $signed(eb[bad]));
            end
          end
        end
        hold_pend = o_vec_valid && !i_vec_ready;
        held_a = o_vec_a;
        held_b = o_vec_b;
      end
    end
  endtask

  initial begin
    int drops;
    fork
      monitor();
    join_none

    // Reset state
    #2;
    chk("rst_ready", o_ready, 0);
    chk("rst_vec_valid", o_vec_valid, 0);
    chk("rst_vec_a_zero", (o_vec_a == '0) ? 1 : 0, 1);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    chk("release_ready", o_ready, 1);

    // Basic fill: a[i]=i, b[i]=-i with consumer ready
    vr = 1'b1;
    send_vec(0, 1'b0);
    idle(1);
    @(negedge i_clk);
    chk("basic_valid_pulse", o_vec_valid, 1);
    chk("basic_a31", o_vec_a[31], 31);
    chk("basic_b5", o_vec_b[5], 251);
    idle(1);
    @(negedge i_clk);
    chk("basic_valid_drop", o_vec_valid, 0);

    // Backpressure: two vectors buffered, third stalls
    vr = 1'b0;
    send_vec(2, 1'b0);
    send_vec(2, 1'b0);
    kind = 2;
    send(1'b1, 1'b0);
    chk("bp_ready_low", o_ready, 0);
    chk("bp_beat0_rejected", last_acc, 0);
    chk("bp_slot_valid", o_vec_valid, 1);
    idle(3);
    chk("bp_ready_still_low", o_ready, 0);
    vr = 1'b1;
    send_vec(2, 1'b0);
    drain();

    // Back-to-back streaming
    ho_cyc.delete();
    kind = 2;
    vr = 1'b1;
    drops = 0;
    for (int i = 0; i < 80; i++) begin
      send(1'b1, 1'b0);
      if (!last_acc) drops++;
    end
    idle(3);
    chk("b2b_ready_drops", drops, 0);
    chk("b2b_vector_count", ho_cyc.size(), 10);
    for (int i = 1; i < ho_cyc.size(); i++)
      chk("b2b_handoff_spacing", ho_cyc[i] - ho_cyc[i-1], 8);

    // Gapped input, index pattern then extreme values
    send_vec(0, 1'b1);
    send_vec(1, 1'b1);
    drain();

    // Clear after 3 beats, then fresh data
    kind = 2;
    repeat (3) send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send_vec(0, 1'b0);
    // Clear coinciding with the last beat discards the vector
    kind = 2;
    repeat (7) send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send_vec(0, 1'b0);
    drain();
    // Clear with a vector parked in the slot
    vr = 1'b0;
    send_vec(2, 1'b0);
    idle(1);
    send(1'b0, 1'b1);
    idle(2);
    chk("clear_slot_kept", o_vec_valid, 1);
    drain();

    // Reset with a slot vector and a partial fill
    vr = 1'b0;
    send_vec(2, 1'b0);
    kind = 2;
    repeat (3) send(1'b1, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    part_n = 0;
    #1;
    chk("midrst_vec_valid", o_vec_valid, 0);
    chk("midrst_vec_a_zero", (o_vec_a == '0) ? 1 : 0, 1);
    chk("midrst_vec_b_zero", (o_vec_b == '0) ? 1 : 0, 1);
    chk("midrst_ready", o_ready, 0);
    idle(2);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", o_ready, 1);
    vr = 1'b1;
    send_vec(0, 1'b0);
    drain();

    // Randomized traffic
    kind = 2;
    for (int i = 0; i < 400; i++) begin
      vr = ($urandom_range(2) != 0);
      send($urandom_range(3) != 0, $urandom_range(15) == 0);
    end
    drain();

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
